// File: rtl/mem_wb_stage_if.sv
// Bundle of memory-stage inputs, fetch handshake and writeback/redirect outputs
// for the MEM/WB pipeline register.
interface mem_wb_stage_if #(
  parameter int unsigned RETIRE_W = 16
);
  logic                i_valid;
  logic                i_stall;
  logic                i_flush;
  logic [1:0]          i_wb;
  logic [2:0]          i_rdst;
  logic [15:0]         i_aluData;
  logic [31:0]         i_memData;
  logic                i_isRet;
  logic                i_isRti;
  logic                i_redirectAck;

  logic                o_regWrite;
  logic [2:0]          o_rdst;
  logic [15:0]         o_wbData;
  logic                o_redirectValid;
  logic [31:0]         o_redirectPc;
  logic                o_flagsLoad;
  logic [3:0]          o_flags;
  logic                o_stallUpstream;
  logic                o_flushUpstream;
  logic                o_protoErr;
  logic [RETIRE_W-1:0] o_retired;

  modport master (
    output i_valid, i_stall, i_flush, i_wb, i_rdst, i_aluData, i_memData,
           i_isRet, i_isRti, i_redirectAck,
    input  o_regWrite, o_rdst, o_wbData, o_redirectValid, o_redirectPc,
           o_flagsLoad, o_flags, o_stallUpstream, o_flushUpstream,
           o_protoErr, o_retired
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_wb, i_rdst, i_aluData, i_memData,
           i_isRet, i_isRti, i_redirectAck,
    output o_regWrite, o_rdst, o_wbData, o_redirectValid, o_redirectPc,
           o_flagsLoad, o_flags, o_stallUpstream, o_flushUpstream,
           o_protoErr, o_retired
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with register-file writeback, retire counter and the
// return-PC redirect/drain sequencer toward fetch.
module mem_wb_stage #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned RETIRE_W     = 16
) (
  input logic           clk,
  input logic           i_reset_n,
  mem_wb_stage_if.slave bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                valid_q;
  logic                new_q;
  logic [1:0]          wb_q;
  logic [2:0]          rdst_q;
  logic [15:0]         aluData_q;
  logic [31:0]         memData_q;
  logic                isRet_q;
  logic                isRti_q;

  logic [31:0]         redirect_pc_q;
  logic [3:0]          flags_q;
  logic                flags_load_q;
  logic                proto_err_q;
  logic [RETIRE_W-1:0] retired_q;

  logic                ret_new;
  logic                enter_redirect;

  // new_q marks a freshly loaded entry, so a RET held by stall fires only once
  assign ret_new        = valid_q & isRet_q & new_q;
  assign enter_redirect = (state_q == IDLE) & ret_new;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      wb_q      <= '0;
      rdst_q    <= '0;
      aluData_q <= '0;
      memData_q <= '0;
      isRet_q   <= 1'b0;
      isRti_q   <= 1'b0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
      new_q   <= 1'b0;
    end else if (bus.i_stall) begin
      new_q <= 1'b0;
    end else begin
      valid_q   <= bus.i_valid;
      new_q     <= 1'b1;
      wb_q      <= bus.i_wb;
      rdst_q    <= bus.i_rdst;
      aluData_q <= bus.i_aluData;
      memData_q <= bus.i_memData;
      isRet_q   <= bus.i_isRet;
      isRti_q   <= bus.i_isRti;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      retired_q <= '0;
    end else if (valid_q && !bus.i_stall) begin
      retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ret_new) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (bus.i_redirectAck) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      redirect_pc_q <= '0;
      flags_q       <= '0;
      flags_load_q  <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      flags_load_q <= enter_redirect & isRti_q;
      if (enter_redirect) begin
        redirect_pc_q <= {4'b0000, memData_q[27:0]};
        flags_q       <= memData_q[31:28];
      end
      if ((state_q != IDLE) && ret_new) proto_err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.o_regWrite      = valid_q & wb_q[0];
    bus.o_rdst          = rdst_q;
    bus.o_wbData        = wb_q[1] ? memData_q[15:0] : aluData_q;
    bus.o_redirectValid = (state_q == REDIRECT);
    bus.o_stallUpstream = (state_q == REDIRECT);
    bus.o_flushUpstream = (state_q == DRAIN);
    bus.o_redirectPc    = redirect_pc_q;
    bus.o_flags         = flags_q;
    bus.o_flagsLoad     = flags_load_q;
    bus.o_protoErr      = proto_err_q;
    bus.o_retired       = retired_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a cycle-level
// behavioural model of writeback, retire counting and the return redirect.
module tb_mem_wb_stage;

  localparam int unsigned DRAIN = 2;

  logic clk;
  logic rst_n;

  mem_wb_stage_if #(.RETIRE_W(16)) bus ();

  mem_wb_stage #(.DRAIN_CYCLES(DRAIN), .RETIRE_W(16)) dut (
    .clk       (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // behavioural model
  bit          m_valid, m_fresh, m_ret, m_rti;
  logic [1:0]  m_wb;
  logic [2:0]  m_rdst;
  logic [15:0] m_alu;
  logic [31:0] m_mem;
  bit          m_redir, m_fl, m_perr;
  int          m_drain_left;
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  int unsigned m_retired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_fresh = 0; m_ret = 0; m_rti = 0;
    m_wb = '0; m_rdst = '0; m_alu = '0; m_mem = '0;
    m_redir = 0; m_fl = 0; m_perr = 0; m_drain_left = 0;
    m_pc = '0; m_flags = '0; m_retired = 0;
  endtask

  task automatic model_edge();
    bit ret_new, idle, was_redir;
    ret_new   = m_valid && m_ret && m_fresh;
    idle      = !m_redir && (m_drain_left == 0);
    was_redir = m_redir;
    if (m_valid && !bus.i_stall) m_retired = (m_retired + 1) % 65536;
    m_fl = 0;
    if (ret_new) begin
      if (idle) begin
        m_redir = 1;
        m_pc    = {4'h0, m_mem[27:0]};
        m_flags = m_mem[31:28];
        m_fl    = m_rti;
      end else begin
        m_perr = 1;
      end
    end
    if (was_redir && bus.i_redirectAck) begin
      m_redir      = 0;
      m_drain_left = DRAIN;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end
    if (bus.i_flush) begin
      m_valid = 0; m_fresh = 0;
    end else if (bus.i_stall) begin
      m_fresh = 0;
    end else begin
      m_valid = bus.i_valid; m_fresh = 1;
      m_wb = bus.i_wb; m_rdst = bus.i_rdst; m_alu = bus.i_aluData;
      m_mem = bus.i_memData; m_ret = bus.i_isRet; m_rti = bus.i_isRti;
    end
  endtask

  task automatic check_all();
    chk("regWrite", 32'(bus.o_regWrite), 32'(m_valid && m_wb[0]));
    if (m_valid) begin
      chk("rdst", 32'(bus.o_rdst), 32'(m_rdst));
      chk("wbData", 32'(bus.o_wbData), 32'(m_wb[1] ? m_mem[15:0] : m_alu));
    end
    chk("redirectValid", 32'(bus.o_redirectValid), 32'(m_redir));
    chk("stallUpstream", 32'(bus.o_stallUpstream), 32'(m_redir));
    chk("flushUpstream", 32'(bus.o_flushUpstream), 32'(m_drain_left > 0));
    chk("flagsLoad", 32'(bus.o_flagsLoad), 32'(m_fl));
    chk("flags", 32'(bus.o_flags), 32'(m_flags));
    chk("redirectPc", bus.o_redirectPc, m_pc);
    chk("protoErr", 32'(bus.o_protoErr), 32'(m_perr));
    chk("retired", 32'(bus.o_retired), m_retired);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit st, input bit fl, input logic [1:0] wb,
                       input logic [2:0] rd, input logic [15:0] alu, input logic [31:0] mem,
                       input bit ret, input bit rti, input bit ack);
    bus.i_valid = v; bus.i_stall = st; bus.i_flush = fl; bus.i_wb = wb;
    bus.i_rdst = rd; bus.i_aluData = alu; bus.i_memData = mem;
    bus.i_isRet = ret; bus.i_isRti = rti; bus.i_redirectAck = ack;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_regWrite"}, 32'(bus.o_regWrite), 32'h0);
    chk({tag, "_rdst"}, 32'(bus.o_rdst), 32'h0);
    chk({tag, "_wbData"}, 32'(bus.o_wbData), 32'h0);
    chk({tag, "_redirectValid"}, 32'(bus.o_redirectValid), 32'h0);
    chk({tag, "_flushUpstream"}, 32'(bus.o_flushUpstream), 32'h0);
    chk({tag, "_redirectPc"}, bus.o_redirectPc, 32'h0);
    chk({tag, "_protoErr"}, 32'(bus.o_protoErr), 32'h0);
    chk({tag, "_retired"}, 32'(bus.o_retired), 32'h0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    idle_in();
    model_reset();
    #1;
    reset_checks("reset");
    check_all();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: ALU op
    drive(1, 0, 0, 2'b01, 3'd3, 16'h1234, 32'h0, 0, 0, 0);
    tick();
    chk("t1_regWrite", 32'(bus.o_regWrite), 32'h1);
    chk("t1_rdst", 32'(bus.o_rdst), 32'h3);
    chk("t1_wbData", 32'(bus.o_wbData), 32'h1234);

    // 2: back-to-back loads
    drive(1, 0, 0, 2'b11, 3'd5, 16'h0, 32'h0000_ABCD, 0, 0, 0);
    tick();
    chk("t2_wbData_a", 32'(bus.o_wbData), 32'hABCD);
    tick();
    chk("t2_wbData_b", 32'(bus.o_wbData), 32'hABCD);
    idle_in();
    tick();
    chk("t2_retired", 32'(bus.o_retired), 32'd3);

    // 3: RTI with delayed ack
    drive(1, 0, 0, 2'b00, 3'd0, 16'h0, 32'hA000_0042, 1, 1, 0);
    tick();
    idle_in();
    tick();
    chk("t3_redirectValid", 32'(bus.o_redirectValid), 32'h1);
    chk("t3_redirectPc", bus.o_redirectPc, 32'h0000_0042);
    chk("t3_flags", 32'(bus.o_flags), 32'hA);
    chk("t3_flagsLoad", 32'(bus.o_flagsLoad), 32'h1);
    tick();
    chk("t3_flagsLoad_once", 32'(bus.o_flagsLoad), 32'h0);
    tick();
    bus.i_redirectAck = 1'b1;
    tick();
    bus.i_redirectAck = 1'b0;
    cnt = bus.o_flushUpstream ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.o_flushUpstream) cnt++;
    end
    chk("t3_drain_len", 32'(cnt), 32'd2);

    // isRti without isRet is ignored
    drive(1, 0, 0, 2'b00, 3'd0, 16'h0, 32'hF000_0077, 0, 1, 0);
    tick();
    idle_in();
    tick();
    chk("rti_alone", 32'(bus.o_redirectValid), 32'h0);

    // 4: stall then stall+flush
    drive(1, 0, 0, 2'b01, 3'd6, 16'h5555, 32'h0, 0, 0, 0);
    tick();
    bus.i_stall = 1'b1;
    bus.i_aluData = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold", 32'(bus.o_wbData), 32'h5555);
    end
    bus.i_flush = 1'b1;
    tick();
    chk("t4_bubble", 32'(bus.o_regWrite), 32'h0);
    idle_in();
    tick();

    // 5: second RET while redirecting
    drive(1, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0000_0100, 1, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0000_0200, 1, 0, 0);
    tick();
    idle_in();
    tick();
    chk("t5_protoErr", 32'(bus.o_protoErr), 32'h1);
    bus.i_redirectAck = 1'b1;
    tick();
    bus.i_redirectAck = 1'b0;
    chk("t5_pc", bus.o_redirectPc, 32'h0000_0100);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_sticky", 32'(bus.o_protoErr), 32'h1);
    chk("t5_no_second", 32'(bus.o_redirectValid), 32'h0);

    // 6: reset in DRAIN
    drive(1, 0, 0, 2'b01, 3'd2, 16'h0, 32'h5000_0300, 1, 1, 0);
    tick();
    idle_in();
    tick();
    bus.i_redirectAck = 1'b1;
    tick();
    bus.i_redirectAck = 1'b0;
    chk("t6_in_drain", 32'(bus.o_flushUpstream), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("t6_async");
    chk("t6_flagsLoad", 32'(bus.o_flagsLoad), 32'h0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_idle", 32'(bus.o_redirectValid), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.i_valid       = ($urandom_range(0, 9) < 7);
      bus.i_stall       = ($urandom_range(0, 99) < 15);
      bus.i_flush       = ($urandom_range(0, 99) < 10);
      bus.i_wb          = 2'($urandom);
      bus.i_rdst        = 3'($urandom);
      bus.i_aluData     = 16'($urandom);
      bus.i_memData     = $urandom;
      bus.i_isRet       = ($urandom_range(0, 99) < 8);
      bus.i_isRti       = 1'($urandom);
      bus.i_redirectAck = ($urandom_range(0, 9) < 4);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
